gate_sweep_gen: RTL and testbench

GATE_SWEEP_GEN -- requirements
Module: gate_sweep_gen

---
 rtl/gate_sweep_pkg.sv | 26 ++
 rtl/gate_sweep_gen_if.sv | 28 ++
 rtl/sweep_misr8.sv | 25 ++
 rtl/gate_sweep_gen.sv | 114 +++++++++++
 tb/tb_gate_sweep_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared types, constants and MISR step function for gate_sweep_gen
// Contents: state_t FSM encoding, NUM_VEC, SIG_W, MISR_POLY, misr_next().
package gate_sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int SIG_W = 8;
  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One MISR step: shift left, fold the polynomial in on a carry-out,
  // then mix the 3-bit response into the low bits.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [2:0] din);
    logic [SIG_W-1:0] t;
    t = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) t = t ^ MISR_POLY;
    return t ^ {5'b0, din};
  endfunction

endpackage

// File: rtl/gate_sweep_gen_if.sv
// rtl/gate_sweep_gen_if.sv - control, stimulus/response and log-read bundle of gate_sweep_gen
// Signals: start/abort (control in), busy/done (status out), a..d (stimulus out),
//          e/f/g (response in), sig (signature out), rd_addr/rd_data (log read).
// Modports: master = the sweep generator, slave = its environment.
interface gate_sweep_gen_if;
  import gate_sweep_pkg::*;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             a, b, c, d;
  logic             e, f, g;
  logic [SIG_W-1:0] sig;
  logic [3:0]       rd_addr;
  logic [2:0]       rd_data;

  modport master (
    input  start, abort, e, f, g, rd_addr,
    output busy, done, a, b, c, d, sig, rd_data
  );

  modport slave (
    output start, abort, e, f, g, rd_addr,
    input  busy, done, a, b, c, d, sig, rd_data
  );

endinterface

// File: rtl/sweep_misr8.sv
// rtl/sweep_misr8.sv - 8-bit MISR compacting the 3-bit gate responses
// Ports: clk, rst_n (sync active-low), clr (zero the signature), en (absorb din),
//        din[2:0] (response {e,f,g}), sig[7:0] (current signature).
module sweep_misr8
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/gate_sweep_gen.sv
// rtl/gate_sweep_gen.sv - exhaustive 4-input gate sweeper with response log and MISR signature
// Parameter: HOLD (1..15) cycles each vector is driven before its response is sampled.
// Ports: clk, rst_n (sync active-low), bus (gate_sweep_gen_if.master): start/abort in,
//        busy/done out, a..d stimulus out, e/f/g response in, sig out, rd_addr/rd_data log read.
module gate_sweep_gen
  import gate_sweep_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_sweep_gen_if.master bus
);

  state_t     state, state_nx;
  logic [3:0] vec, vec_nx;
  logic [3:0] hold_cnt, hold_nx;
  logic [3:0] stim, stim_nx;
  logic       misr_clr, misr_en;
  logic [2:0] resp;
  logic [2:0] rd_q;
  logic [2:0] log_mem [NUM_VEC];

  assign resp = {bus.e, bus.f, bus.g};

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    hold_nx  = hold_cnt;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = DRIVE;
          vec_nx   = '0;
          hold_nx  = '0;
          misr_clr = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (hold_cnt == 4'(HOLD - 1)) begin
          state_nx = SAMPLE;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else begin
          misr_en = 1'b1;
          if (vec == 4'(NUM_VEC - 1)) begin
            state_nx = DONE;
          end else begin
            vec_nx   = vec + 4'd1;
            state_nx = DRIVE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Stimulus is registered from the next-state view so a..d change on the
    // same edge that enters DRIVE and drop to zero on the edge leaving the sweep.
    stim_nx = (state_nx == DRIVE || state_nx == SAMPLE) ? vec_nx : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      hold_cnt <= '0;
      stim     <= '0;
      rd_q     <= '0;
    end else begin
      state    <= state_nx;
      vec      <= vec_nx;
      hold_cnt <= hold_nx;
      stim     <= stim_nx;
      rd_q     <= log_mem[bus.rd_addr];
    end
  end

  // Log storage has no reset; the read above sees the pre-write value on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n && misr_en) begin
      log_mem[vec] <= resp;
    end
  end

  sweep_misr8 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (resp),
    .sig   (bus.sig)
  );

  assign bus.a       = stim[0];
  assign bus.b       = stim[1];
  assign bus.c       = stim[2];
  assign bus.d       = stim[3];
  assign bus.busy    = (state == DRIVE) || (state == SAMPLE);
  assign bus.done    = (state == DONE);
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_gate_sweep_gen.sv
// tb/tb_gate_sweep_gen.sv - directed self-checking bench for gate_sweep_gen (HOLD=2 and HOLD=1)
module tb_gate_sweep_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_gen_if bus2 ();
  gate_sweep_gen_if bus1 ();

  gate_sweep_gen #(.HOLD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  gate_sweep_gen #(.HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  // Responder for dut2: 0 = all zero, 1 = e=NAND4, 2 = f=1 only.
  int mode2 = 0;
  assign bus2.e = (mode2 == 1) ? ~(bus2.a & bus2.b & bus2.c & bus2.d) : 1'b0;
  assign bus2.f = (mode2 == 2);
  assign bus2.g = 1'b0;
  assign bus1.e = ~(bus1.a & bus1.b & bus1.c & bus1.d);
  assign bus1.f = 1'b0;
  assign bus1.g = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s, input logic [2:0] din);
    logic [7:0] t;
    t = {s[6:0], 1'b0};
    if (s[7]) t = t ^ 8'h1D;
    return t ^ {5'b0, din};
  endfunction

  task automatic rd2(input logic [3:0] addr, output logic [2:0] v);
    bus2.rd_addr = addr;
    tick();
    v = bus2.rd_data;
  endtask

  // Starts dut2 (start sampled at cycle 0) and observes cycles 1..60.
  // Optional start pulse / abort / reset at given cycles; abort or reset ends
  // the run one cycle later with stop_cyc set.
  task automatic sweep2(input int pulse_at, input int abort_at, input int rst_at,
                        output int done_cyc, output int npulse, output int stop_cyc);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    done_cyc = -1;
    npulse = 0;
    stop_cyc = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus2.done) begin
        npulse++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == pulse_at) bus2.start = 1'b1;
      if (cyc == abort_at) bus2.abort = 1'b1;
      if (cyc == rst_at) rst_n = 1'b0;
      tick();
      bus2.start = 1'b0;
      bus2.abort = 1'b0;
      rst_n = 1'b1;
      if (cyc == abort_at || cyc == rst_at) begin
        stop_cyc = cyc + 1;
        break;
      end
    end
  endtask

  logic [7:0] exp_nand;
  logic [7:0] exp_abort;
  logic [2:0] v;
  int dc, np, sc;

  initial begin
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.rd_addr = 4'd0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.rd_addr = 4'd0;

    exp_nand = 8'h00;
    for (int k = 0; k < 16; k++) exp_nand = mstep(exp_nand, (k == 15) ? 3'b000 : 3'b100);
    exp_abort = 8'h00;
    for (int k = 0; k < 3; k++) exp_abort = mstep(exp_abort, 3'b010);

    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", bus2.busy, 0);
    chk("rst_done", bus2.done, 0);
    chk("rst_stim", {bus2.d, bus2.c, bus2.b, bus2.a}, 0);
    chk("rst_sig", bus2.sig, 0);
    chk("rst_rd_data", bus2.rd_data, 0);
    chk("rst_busy_h1", bus1.busy, 0);
    rst_n = 1'b1;
    tick();

    // All-zero responder
    mode2 = 0;
    sweep2(-1, -1, -1, dc, np, sc);
    chk("zero_done_cyc", dc, 49);
    chk("zero_npulse", np, 1);
    chk("zero_sig", bus2.sig, 8'h00);
    for (int k = 0; k < 16; k++) begin
      rd2(4'(k), v);
      chk($sformatf("zero_log%0d", k), v, 3'b000);
    end

    // NAND4 responder
    mode2 = 1;
    sweep2(-1, -1, -1, dc, np, sc);
    chk("nand_done_cyc", dc, 49);
    chk("nand_npulse", np, 1);
    chk("nand_sig", bus2.sig, exp_nand);
    for (int k = 0; k < 16; k++) begin
      rd2(4'(k), v);
      chk($sformatf("nand_log%0d", k), v, (k == 15) ? 3'b000 : 3'b100);
    end

    // Start pulse mid-sweep is ignored
    sweep2(5, -1, -1, dc, np, sc);
    chk("pulse_done_cyc", dc, 49);
    chk("pulse_npulse", np, 1);
    chk("pulse_sig", bus2.sig, exp_nand);

    // Abort at cycle 10 while vector 3 is driven
    mode2 = 2;
    sweep2(-1, 10, -1, dc, np, sc);
    chk("abort_stop_cyc", sc, 11);
    chk("abort_busy", bus2.busy, 0);
    chk("abort_done", bus2.done, 0);
    chk("abort_stim", {bus2.d, bus2.c, bus2.b, bus2.a}, 0);
    chk("abort_sig", bus2.sig, exp_abort);
    np = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus2.done || bus2.busy) np++;
      tick();
    end
    chk("abort_quiet", np, 0);
    for (int k = 0; k < 4; k++) begin
      rd2(4'(k), v);
      chk($sformatf("abort_log%0d", k), v, (k == 3) ? 3'b100 : 3'b010);
    end
    chk("abort_sig_kept", bus2.sig, exp_abort);

    // Reset pulse at cycle 20, then a clean sweep
    mode2 = 1;
    sweep2(-1, -1, 20, dc, np, sc);
    chk("rst20_stop_cyc", sc, 21);
    chk("rst20_busy", bus2.busy, 0);
    chk("rst20_done", bus2.done, 0);
    chk("rst20_stim", {bus2.d, bus2.c, bus2.b, bus2.a}, 0);
    chk("rst20_sig", bus2.sig, 0);
    chk("rst20_rd_data", bus2.rd_data, 0);
    tick();
    sweep2(-1, -1, -1, dc, np, sc);
    chk("rerun_done_cyc", dc, 49);
    chk("rerun_npulse", np, 1);
    chk("rerun_sig", bus2.sig, exp_nand);
    rd2(4'd0, v);
    chk("rerun_log0", v, 3'b100);
    rd2(4'd15, v);
    chk("rerun_log15", v, 3'b000);

    // HOLD=1 instance
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    dc = -1;
    np = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc <= 32) chk($sformatf("h1_a_cyc%0d", cyc), bus1.a, ((cyc - 1) / 2) % 2);
      if (bus1.done) begin
        np++;
        if (dc < 0) dc = cyc;
      end
      tick();
    end
    chk("h1_done_cyc", dc, 33);
    chk("h1_npulse", np, 1);
    chk("h1_sig", bus1.sig, exp_nand);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
